mem_req_arbiter: RTL and testbench
==================================

Name: mem_req_arbiter

Overview:
- Shares one SRAM-like memory port between the instruction-fetch requester and the data (MEM-stage) requester.
- Tracks outstanding transactions in an in-order owner FIFO and routes each response back to the requester that issued it.
- When the write-back stage raises `cancel` for an exception or eret redirect, responses to in-flight instruction fetches are discarded.
- Sits between the pipeline's fetch/MEM interfaces and the bus bridge.

Parameters:
- MAX_OUTSTANDING, 4, depth of the owner FIFO (power of two, ≥2).
- STARVE_LIMIT, 8, consecutive data grants allowed while inst waits (used only with ARB_STARVE_GUARD_EN).

Ports:
- clk  in  1  clock
- resetn  in  1  asynchronous active-low reset
- cancel  in  1  pipeline flush from WB; kills outstanding inst fetches
- inst_req  in  1  fetch request valid
- inst_addr  in  32  fetch address
- inst_addr_ok  out  1  fetch request accepted this cycle
- inst_data_ok  out  1  fetch data valid
- inst_rdata  out  32  fetch data
- data_req  in  1  data request valid
- data_wr  in  1  1 = store
- data_size  in  2  0 = byte, 1 = half, 2 = word
- data_addr  in  32  data address
- data_wdata  in  32  store data
- data_addr_ok  out  1  data request accepted
- data_data_ok  out  1  load data valid / store complete
- data_rdata  out  32  load data
- bus_req, bus_wr, bus_size[1:0], bus_addr[31:0], bus_wdata[31:0]  out  downstream request
- bus_addr_ok  in  1  downstream accepted request
- bus_data_ok  in  1  downstream response valid (responses always in issue order)
- bus_rdata  in  32  downstream response data
- arb_idle  out  1  FIFO empty and no request presented

Behaviour:
- Reset (resetn low, asynchronous): FIFO pointers = 0, count = 0, all discard bits = 0, starve counter = 0. All *_ok outputs go to 0. bus_req = 0.
- Arbitration is combinational in the current cycle.
  - Select data if data_req = 1; otherwise select inst if inst_req = 1 and cancel = 0.
  - Fixed priority: data over inst.
- The selected requester drives bus_* directly. Inst requests drive bus_wr = 0 and bus_size = 2.
- bus_req = selected_valid & (count < MAX_OUTSTANDING). When full, bus_req = 0 and no addr_ok is raised.
- Grant: bus_req & bus_addr_ok.
  - addr_ok is raised only to the selected requester, in the same cycle as the grant.
  - On grant, push {owner, discard = 0} into the FIFO, where owner is 1 for data and 0 for inst.
- Response: bus_data_ok with count > 0 pops the FIFO head.
  - If owner = 1: data_data_ok = 1.
  - If owner = 0 and discard = 0: inst_data_ok = 1.
  - If discard = 1: the response is dropped silently.
  - rdata outputs are bus_rdata passed through; they are valid only while the matching data_ok = 1.
- bus_data_ok with count = 0 is a protocol error: ignored, no pop, no data_ok.
- Push and pop in the same cycle: count unchanged. A push is still blocked when count == MAX_OUTSTANDING at the start of the cycle (no same-cycle slot reuse).
- cancel = 1 sets discard on every valid FIFO entry with owner = 0, including the head being popped that cycle. The popped inst response is therefore dropped.
- cancel = 1 never grants inst in that cycle (fetch redirect requires a fresh request). Data entries and data grants are unaffected.
- Pointers wrap modulo MAX_OUTSTANDING. count width = clog2(MAX_OUTSTANDING)+1.
- arb_idle = (count == 0) & ~inst_req & ~data_req.

Optional Feature:
- Macro: ARB_STARVE_GUARD_EN.
- Defined:
  - A counter increments on each data grant while inst_req = 1 and cancel = 0.
  - It clears on any inst grant or when inst_req = 0.
  - When counter == STARVE_LIMIT, inst is selected over data for that cycle; the counter clears on that inst grant.
- Undefined: pure fixed data priority; counter logic is absent.

Test Plan:
- Reset mid-transaction: 2 entries outstanding, drop resetn → count = 0, no data_ok on subsequent bus_data_ok, arb_idle = 1 once reqs drop.
- Simultaneous inst_req and data_req, bus_addr_ok = 1 → data_addr_ok = 1, inst_addr_ok = 0, bus_addr = data_addr; next cycle inst granted.
- Issue inst A, data B, inst C, then return 0x11111111, 0x22222222, 0x33333333 → inst_data_ok with 0x11111111, data_data_ok with 0x22222222, inst_data_ok with 0x33333333, in order.
- Issue 2 inst fetches, pulse cancel, return both responses → no inst_data_ok; a new inst fetch issued afterwards returns 0xBFC00380-fetch data with inst_data_ok = 1.
- Fill 4 entries without responses → bus_req = 0 with requests pending. One bus_data_ok → request accepted the following cycle, count returns to 4.
- ARB_STARVE_GUARD_EN, data_req and inst_req held high, STARVE_LIMIT = 8 → exactly 8 data grants, then 1 inst grant, repeating.

Source files
------------

// File: rtl/mem_req_arbiter.sv
// Shares one memory port between fetch and MEM-stage requesters.
// Optional macro ARB_STARVE_GUARD_EN bounds back-to-back data grants.
module mem_req_arbiter #(
    parameter int MAX_OUTSTANDING = 4,
    parameter int STARVE_LIMIT    = 8
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        cancel,
    input  logic        inst_req,
    input  logic [31:0] inst_addr,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,
    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,
    output logic        bus_req,
    output logic        bus_wr,
    output logic [1:0]  bus_size,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    input  logic        bus_addr_ok,
    input  logic        bus_data_ok,
    input  logic [31:0] bus_rdata,
    output logic        arb_idle
);

    localparam int PW = $clog2(MAX_OUTSTANDING);
    localparam int CW = PW + 1;

    logic [PW-1:0]              wptr_q, wptr_d;
    logic [PW-1:0]              rptr_q, rptr_d;
    logic [CW-1:0]              cnt_q, cnt_d;
    logic [MAX_OUTSTANDING-1:0] own_q, own_d;
    logic [MAX_OUTSTANDING-1:0] disc_q, disc_d;

    logic inst_ok;
    logic sel_inst;
    logic sel_data;
    logic not_full;
    logic grant;
    logic pop;
    logic head_own;
    logic head_disc;
    logic force_inst;

`ifdef ARB_STARVE_GUARD_EN
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    logic [SW-1:0] starve_q, starve_d;
    assign force_inst = (starve_q == SW'(STARVE_LIMIT));
`else
    logic unused_starve;
    assign force_inst    = 1'b0;
    assign unused_starve = (STARVE_LIMIT == 0);
`endif

    // Pick a requester, drive the bus and decode the FIFO head.
    always_comb begin
        inst_ok  = inst_req & ~cancel;
        sel_inst = inst_ok & (~data_req | force_inst);
        sel_data = data_req & ~sel_inst;
        not_full = (cnt_q < CW'(MAX_OUTSTANDING));
        // Gate with resetn so no request leaks out while held in reset.
        bus_req  = resetn & (sel_inst | sel_data) & not_full;
        grant    = bus_req & bus_addr_ok;

        inst_addr_ok = grant & sel_inst;
        data_addr_ok = grant & sel_data;

        bus_wr    = sel_data & data_wr;
        bus_size  = sel_data ? data_size : 2'd2;
        bus_addr  = sel_data ? data_addr : inst_addr;
        bus_wdata = sel_data ? data_wdata : 32'h0;

        pop       = bus_data_ok & (cnt_q != '0);
        head_own  = own_q[rptr_q];
        // A cancel in the pop cycle also kills the head inst response.
        head_disc = disc_q[rptr_q] | (cancel & ~head_own);

        data_data_ok = pop & head_own;
        inst_data_ok = pop & ~head_own & ~head_disc;
        data_rdata   = bus_rdata;
        inst_rdata   = bus_rdata;

        arb_idle = (cnt_q == '0) & ~inst_req & ~data_req;
    end

    // Owner FIFO next state: push on grant, pop on response, mark kills.
    always_comb begin
        own_d  = own_q;
        // Marking empty slots too is harmless: a push rewrites the bit.
        disc_d = disc_q | ({MAX_OUTSTANDING{cancel}} & ~own_q);
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        cnt_d  = cnt_q;
        if (grant) begin
            own_d[wptr_q]  = sel_data;
            disc_d[wptr_q] = 1'b0;
            wptr_d         = wptr_q + 1'b1;
        end
        if (pop) begin
            rptr_d = rptr_q + 1'b1;
        end
        unique case ({grant, pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
`ifdef ARB_STARVE_GUARD_EN
        starve_d = starve_q;
        if (~inst_req || (grant && sel_inst)) begin
            starve_d = '0;
        end else if (grant && sel_data && !cancel) begin
            starve_d = starve_q + 1'b1;
        end
`endif
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wptr_q   <= '0;
            rptr_q   <= '0;
            cnt_q    <= '0;
            own_q    <= '0;
            disc_q   <= '0;
`ifdef ARB_STARVE_GUARD_EN
            starve_q <= '0;
`endif
        end else begin
            wptr_q   <= wptr_d;
            rptr_q   <= rptr_d;
            cnt_q    <= cnt_d;
            own_q    <= own_d;
            disc_q   <= disc_d;
`ifdef ARB_STARVE_GUARD_EN
            starve_q <= starve_d;
`endif
        end
    end

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Directed self-checking bench for mem_req_arbiter.
// Starvation-guard vectors run only when ARB_STARVE_GUARD_EN is set.
module tb_mem_req_arbiter;

    logic        clk = 1'b0;
    logic        resetn;
    logic        cancel;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok;
    logic        inst_data_ok;
    logic [31:0] inst_rdata;
    logic        data_req;
    logic        data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic        data_addr_ok;
    logic        data_data_ok;
    logic [31:0] data_rdata;
    logic        bus_req;
    logic        bus_wr;
    logic [1:0]  bus_size;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic        bus_addr_ok;
    logic        bus_data_ok;
    logic [31:0] bus_rdata;
    logic        arb_idle;

    int nchk = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    mem_req_arbiter #(
        .MAX_OUTSTANDING(4),
        .STARVE_LIMIT   (8)
    ) dut (
        .clk         (clk),
        .resetn      (resetn),
        .cancel      (cancel),
        .inst_req    (inst_req),
        .inst_addr   (inst_addr),
        .inst_addr_ok(inst_addr_ok),
        .inst_data_ok(inst_data_ok),
        .inst_rdata  (inst_rdata),
        .data_req    (data_req),
        .data_wr     (data_wr),
        .data_size   (data_size),
        .data_addr   (data_addr),
        .data_wdata  (data_wdata),
        .data_addr_ok(data_addr_ok),
        .data_data_ok(data_data_ok),
        .data_rdata  (data_rdata),
        .bus_req     (bus_req),
        .bus_wr      (bus_wr),
        .bus_size    (bus_size),
        .bus_addr    (bus_addr),
        .bus_wdata   (bus_wdata),
        .bus_addr_ok (bus_addr_ok),
        .bus_data_ok (bus_data_ok),
        .bus_rdata   (bus_rdata),
        .arb_idle    (arb_idle)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic quiet();
        cancel      = 1'b0;
        inst_req    = 1'b0;
        data_req    = 1'b0;
        bus_addr_ok = 1'b0;
        bus_data_ok = 1'b0;
    endtask

    initial begin
        resetn     = 1'b0;
        quiet();
        inst_addr  = 32'h0;
        data_wr    = 1'b0;
        data_size  = 2'd2;
        data_addr  = 32'h0;
        data_wdata = 32'h0;
        bus_rdata  = 32'h0;
        repeat (3) cyc();

        // reset state
        check("rst_idle", 32'(arb_idle), 32'd1);
        check("rst_busreq", 32'(bus_req), 32'd0);
        check("rst_iok", 32'(inst_data_ok), 32'd0);
        check("rst_dok", 32'(data_data_ok), 32'd0);
        resetn = 1'b1;
        cyc();

        // simultaneous requests: data wins, inst next
        inst_req = 1'b1; inst_addr = 32'h0000_1000;
        data_req = 1'b1; data_addr = 32'h0000_2000;
        data_wr = 1'b0; data_size = 2'd1;
        bus_addr_ok = 1'b1;
        #1;
        check("sim_daok", 32'(data_addr_ok), 32'd1);
        check("sim_iaok", 32'(inst_addr_ok), 32'd0);
        check("sim_addr", bus_addr, 32'h0000_2000);
        check("sim_size", 32'(bus_size), 32'd1);
        cyc();
        data_req = 1'b0;
        #1;
        check("sim2_iaok", 32'(inst_addr_ok), 32'd1);
        check("sim2_addr", bus_addr, 32'h0000_1000);
        check("sim2_size", 32'(bus_size), 32'd2);
        check("sim2_wr", 32'(bus_wr), 32'd0);
        cyc();
        quiet();
        bus_data_ok = 1'b1; bus_rdata = 32'hAAAA_0001;
        #1;
        check("sim_r1_dok", 32'(data_data_ok), 32'd1);
        check("sim_r1_iok", 32'(inst_data_ok), 32'd0);
        check("sim_r1_dat", data_rdata, 32'hAAAA_0001);
        cyc();
        bus_rdata = 32'hAAAA_0002;
        #1;
        check("sim_r2_iok", 32'(inst_data_ok), 32'd1);
        check("sim_r2_dok", 32'(data_data_ok), 32'd0);
        check("sim_r2_dat", inst_rdata, 32'hAAAA_0002);
        cyc();
        // response with empty FIFO is ignored
        bus_rdata = 32'hDEAD_BEEF;
        #1;
        check("err_iok", 32'(inst_data_ok), 32'd0);
        check("err_dok", 32'(data_data_ok), 32'd0);
        check("err_idle", 32'(arb_idle), 32'd1);
        cyc();
        quiet();

        // in-order routing: inst A, data B, inst C
        bus_addr_ok = 1'b1;
        inst_req = 1'b1; inst_addr = 32'h0000_0A00;
        #1 check("ord_a", 32'(inst_addr_ok), 32'd1);
        cyc();
        inst_req = 1'b0;
        data_req = 1'b1; data_wr = 1'b1; data_size = 2'd0;
        data_addr = 32'h0000_0B00; data_wdata = 32'h0000_00BB;
        #1;
        check("ord_b", 32'(data_addr_ok), 32'd1);
        check("ord_b_wr", 32'(bus_wr), 32'd1);
        check("ord_b_wd", bus_wdata, 32'h0000_00BB);
        cyc();
        data_req = 1'b0;
        inst_req = 1'b1; inst_addr = 32'h0000_0C00;
        #1 check("ord_c", 32'(inst_addr_ok), 32'd1);
        cyc();
        quiet();
        bus_data_ok = 1'b1; bus_rdata = 32'h1111_1111;
        #1;
        check("ord_r1_iok", 32'(inst_data_ok), 32'd1);
        check("ord_r1_dok", 32'(data_data_ok), 32'd0);
        check("ord_r1_dat", inst_rdata, 32'h1111_1111);
        cyc();
        bus_rdata = 32'h2222_2222;
        #1;
        check("ord_r2_dok", 32'(data_data_ok), 32'd1);
        check("ord_r2_iok", 32'(inst_data_ok), 32'd0);
        check("ord_r2_dat", data_rdata, 32'h2222_2222);
        cyc();
        bus_rdata = 32'h3333_3333;
        #1;
        check("ord_r3_iok", 32'(inst_data_ok), 32'd1);
        check("ord_r3_dat", inst_rdata, 32'h3333_3333);
        cyc();
        quiet();

        // cancel kills two in-flight fetches
        bus_addr_ok = 1'b1;
        inst_req = 1'b1; inst_addr = 32'h0000_0100;
        #1 check("can_f1", 32'(inst_addr_ok), 32'd1);
        cyc();
        inst_addr = 32'h0000_0104;
        #1 check("can_f2", 32'(inst_addr_ok), 32'd1);
        cyc();
        cancel = 1'b1;
        #1;
        check("can_noreq", 32'(bus_req), 32'd0);
        check("can_noaok", 32'(inst_addr_ok), 32'd0);
        cyc();
        quiet();
        bus_data_ok = 1'b1; bus_rdata = 32'h0000_0F01;
        #1 check("can_r1", 32'(inst_data_ok), 32'd0);
        cyc();
        bus_rdata = 32'h0000_0F02;
        #1 check("can_r2", 32'(inst_data_ok), 32'd0);
        cyc();
        quiet();
        bus_addr_ok = 1'b1;
        inst_req = 1'b1; inst_addr = 32'hBFC0_0380;
        #1;
        check("can_new_aok", 32'(inst_addr_ok), 32'd1);
        check("can_new_addr", bus_addr, 32'hBFC0_0380);
        cyc();
        quiet();
        bus_data_ok = 1'b1; bus_rdata = 32'h3C1A_0000;
        #1;
        check("can_new_iok", 32'(inst_data_ok), 32'd1);
        check("can_new_dat", inst_rdata, 32'h3C1A_0000);
        cyc();
        quiet();

        // cancel in the same cycle as the head inst pops
        bus_addr_ok = 1'b1;
        inst_req = 1'b1; inst_addr = 32'h0000_0200;
        #1 check("cpop_aok", 32'(inst_addr_ok), 32'd1);
        cyc();
        quiet();
        cancel = 1'b1; bus_data_ok = 1'b1; bus_rdata = 32'h0000_0202;
        #1 check("cpop_iok", 32'(inst_data_ok), 32'd0);
        cyc();
        quiet();
        #1 check("cpop_idle", 32'(arb_idle), 32'd1);

        // fill four entries, then stall until a slot frees
        bus_addr_ok = 1'b1;
        data_req = 1'b1; data_wr = 1'b1; data_size = 2'd2;
        for (int i = 0; i < 4; i++) begin
            data_addr = 32'h0000_3000 + 32'(i * 4);
            #1 check($sformatf("full_fill%0d", i),
                     32'(data_addr_ok), 32'd1);
            cyc();
        end
        #1;
        check("full_busreq", 32'(bus_req), 32'd0);
        check("full_daok", 32'(data_addr_ok), 32'd0);
        cyc();
        bus_data_ok = 1'b1;
        #1;
        check("full_pop_busreq", 32'(bus_req), 32'd0);
        check("full_pop_dok", 32'(data_data_ok), 32'd1);
        cyc();
        bus_data_ok = 1'b0;
        #1 check("full_refill", 32'(data_addr_ok), 32'd1);
        cyc();
        #1 check("full_again", 32'(bus_req), 32'd0);
        cyc();
        quiet();
        bus_data_ok = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1 check($sformatf("full_drain%0d", i),
                     32'(data_data_ok), 32'd1);
            cyc();
        end
        quiet();
        #1 check("full_idle", 32'(arb_idle), 32'd1);

        // reset while two fetches are outstanding
        bus_addr_ok = 1'b1; inst_req = 1'b1;
        repeat (2) begin
            #1 check("mrst_issue", 32'(inst_addr_ok), 32'd1);
            cyc();
        end
        inst_req = 1'b0; data_req = 1'b1;
        resetn = 1'b0;
        #1;
        check("mrst_busreq", 32'(bus_req), 32'd0);
        check("mrst_daok", 32'(data_addr_ok), 32'd0);
        cyc();
        quiet();
        resetn = 1'b1;
        #1 check("mrst_idle0", 32'(arb_idle), 32'd1);
        cyc();
        bus_data_ok = 1'b1;
        #1;
        check("mrst_iok", 32'(inst_data_ok), 32'd0);
        check("mrst_dok", 32'(data_data_ok), 32'd0);
        check("mrst_idle", 32'(arb_idle), 32'd1);
        cyc();
        quiet();

`ifdef ARB_STARVE_GUARD_EN
        // eight data grants, then one inst grant, repeating
        inst_req = 1'b1; data_req = 1'b1; data_wr = 1'b0;
        bus_addr_ok = 1'b1; bus_data_ok = 1'b1;
        for (int i = 0; i < 18; i++) begin
            #1;
            check($sformatf("stv_d%0d", i), 32'(data_addr_ok),
                  (i % 9 == 8) ? 32'd0 : 32'd1);
            check($sformatf("stv_i%0d", i), 32'(inst_addr_ok),
                  (i % 9 == 8) ? 32'd1 : 32'd0);
            cyc();
        end
        quiet();
        bus_data_ok = 1'b1;
        cyc();
        quiet();
`endif

        repeat (2) cyc();
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
